// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver with per-channel direction FSM and reversal deadtime.
// Define MOTOR_SOFT_RAMP_EN to ramp applied duty in 32-count steps.
module motor_pwm_channel #(
    parameter int DEAD_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boundary,
    input  logic [7:0] count,
    input  logic [4:0] cmd,
    output logic       in1,
    output logic       in2,
    output logic       en,
    output logic       in_dead
);

    localparam int DEAD_INIT = (DEAD_PERIODS < 1) ? 1 : DEAD_PERIODS;
    localparam int DW = $clog2(DEAD_INIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DEAD
    } state_t;

    state_t state, state_n;
    logic dir, dir_n;
    logic [7:0] duty, duty_n;
    logic [DW-1:0] dcnt, dcnt_n;

    logic neutral;
    logic cmd_rev;
    logic [7:0] target;
    logic [7:0] entry_duty;
    logic [7:0] ramp_duty;

    assign neutral = cmd[0];
    assign cmd_rev = cmd[1];
    assign target = (cmd[4:2] == 3'd7) ? 8'd224 : {cmd[4:2] + 3'd1, 5'd0};

    always_comb begin
        entry_duty = target;
        ramp_duty = target;
`ifdef MOTOR_SOFT_RAMP_EN
        entry_duty = 8'd32;
        if ({1'b0, duty} + 9'd32 < {1'b0, target})
            ramp_duty = duty + 8'd32;
        else if ({1'b0, duty} > {1'b0, target} + 9'd32)
            ramp_duty = duty - 8'd32;
`endif
    end

    always_comb begin
        state_n = state;
        dir_n = dir;
        duty_n = duty;
        dcnt_n = dcnt;
        if (boundary) begin
            unique case (state)
                IDLE: begin
                    if (!neutral) begin
                        state_n = DRIVE;
                        dir_n = cmd_rev;
                        duty_n = entry_duty;
                    end
                end
                DRIVE: begin
                    if (neutral) begin
                        state_n = IDLE;
                    end else if (cmd_rev != dir) begin
                        state_n = DEAD;
                        dcnt_n = DW'(DEAD_INIT);
                    end else begin
                        duty_n = ramp_duty;
                    end
                end
                DEAD: begin
                    // Target changes are only looked at once the full deadtime has run out
                    if (dcnt <= DW'(1)) begin
                        dcnt_n = '0;
                        if (neutral) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DRIVE;
                            dir_n = cmd_rev;
                            duty_n = entry_duty;
                        end
                    end else begin
                        dcnt_n = dcnt - DW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dir <= 1'b0;
            duty <= '0;
            dcnt <= '0;
            en <= 1'b0;
            in1 <= 1'b0;
            in2 <= 1'b0;
        end else begin
            state <= state_n;
            dir <= dir_n;
            duty <= duty_n;
            dcnt <= dcnt_n;
            en <= (state == DRIVE) && (count < duty);
            in1 <= (state == DRIVE) && !dir;
            in2 <= (state == DRIVE) && dir;
        end
    end

    assign in_dead = (state == DEAD);

endmodule

module motor_pwm_driver #(
    parameter int PWM_DIV = 49,
    parameter int DEAD_PERIODS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] MC1,
    input  logic [4:0] MC2,
    output logic       R_IN1,
    output logic       R_IN2,
    output logic       R_EN,
    output logic       L_IN1,
    output logic       L_IN2,
    output logic       L_EN,
    output logic       BUSY
);

    localparam int PW = (PWM_DIV < 1) ? 1 : $clog2(PWM_DIV + 1);

    logic [4:0] mc1_q;
    logic [4:0] mc2_q;
    logic [PW-1:0] pre;
    logic [7:0] count;
    logic tick;
    logic boundary;
    logic r_dead;
    logic l_dead;

    assign tick = (pre == PW'(PWM_DIV));
    assign boundary = tick && (count == 8'd255);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mc1_q <= '0;
            mc2_q <= '0;
            pre <= '0;
            count <= '0;
            BUSY <= 1'b0;
        end else begin
            mc1_q <= MC1;
            mc2_q <= MC2;
            pre <= tick ? '0 : pre + PW'(1);
            if (tick)
                count <= count + 8'd1;
            BUSY <= r_dead || l_dead;
        end
    end

    motor_pwm_channel #(
        .DEAD_PERIODS(DEAD_PERIODS)
    ) u_right (
        .clk(CLK),
        .rst(RST),
        .boundary(boundary),
        .count(count),
        .cmd(mc1_q),
        .in1(R_IN1),
        .in2(R_IN2),
        .en(R_EN),
        .in_dead(r_dead)
    );

    motor_pwm_channel #(
        .DEAD_PERIODS(DEAD_PERIODS)
    ) u_left (
        .clk(CLK),
        .rst(RST),
        .boundary(boundary),
        .count(count),
        .cmd(mc2_q),
        .in1(L_IN1),
        .in2(L_IN2),
        .en(L_EN),
        .in_dead(l_dead)
    );

endmodule
